// File: rtl/hh_membrane_update.sv
// -----------------------------------------------------------------------------
// hh_membrane_update
//
// Hodgkin-Huxley membrane integrator. Each accepted set of gating variables
// (n, m, h) together with a stimulus current and a time step drives one
// forward-Euler update of the membrane potential. The K, Na and leak currents
// are evaluated over a fixed nine-state sequence that shares a single
// multiplier. Each state performs exactly one multiply.
//
// The internal potential v_acc is held in uV. V is presented in mV,
// truncated toward zero.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   gate_valid   n/m/h/i_stim/dt valid; accepted only while busy = 0
//   n, m, h      gating variables x1000, unsigned, 0..1000
//   i_stim       stimulus current, signed, 0.01 uA/cm^2 units
//   dt           time step in us, unsigned
//   V            membrane potential in mV, signed; stable between updates
//   v_valid      one-cycle pulse: V has just been updated
//   spike        one-cycle pulse with v_valid on an upward 0 mV crossing
//   spike_count  spikes since reset (wraps)
//   busy         update sequence in progress
//   overrun      one-cycle pulse: gate_valid arrived while busy (ignored)
//
// Configuration
//   HH_SPIKE_CNT_EN  defined: spike_count counter is implemented.
//                    undefined: spike_count is tied to zero.
// -----------------------------------------------------------------------------
module hh_membrane_update #(
    parameter int V_REST = -65000,
    parameter int V_MIN  = -120000,
    parameter int V_MAX  = 80000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               gate_valid,
    input  logic [15:0]        n,
    input  logic [15:0]        m,
    input  logic [15:0]        h,
    input  logic signed [15:0] i_stim,
    input  logic [15:0]        dt,
    output logic signed [15:0] V,
    output logic               v_valid,
    output logic               spike,
    output logic [15:0]        spike_count,
    output logic               busy,
    output logic               overrun
);

    typedef enum logic [3:0] {
        S_IDLE, S_N2, S_N4, S_M2, S_M3, S_MH, S_IK, S_INA, S_IL, S_UPD
    } state_t;

    localparam logic signed [47:0] V_MIN_W = 48'(V_MIN);
    localparam logic signed [47:0] V_MAX_W = 48'(V_MAX);

    state_t state, state_nxt;

    // Captured inputs
    logic [15:0]        n_r, m_r, h_r, dt_r;
    logic signed [15:0] istim_r;

    // Intermediate results
    logic signed [47:0] n2_r, n4_r, m2_r, m3_r, gna_r;
    logic signed [47:0] ik_r, ina_r, il_r;

    // Membrane potential in uV
    logic signed [31:0] v_acc;

    logic signed [47:0] v48, mul_a, mul_b, prod;
    logic signed [47:0] istim_w, i_sum, v_new;
    logic signed [31:0] v_sat;
    logic               spike_now;

    function automatic logic signed [47:0] div1000(input logic signed [47:0] x);
        return x / 48'sd1000;
    endfunction

    function automatic logic signed [47:0] div10(input logic signed [47:0] x);
        return x / 48'sd10;
    endfunction

    function automatic logic signed [47:0] ext_u(input logic [15:0] x);
        return {32'd0, x};
    endfunction

    function automatic logic signed [31:0] sat_v(input logic signed [47:0] x);
        if (x < V_MIN_W)
            return V_MIN;
        else if (x > V_MAX_W)
            return V_MAX;
        else
            return x[31:0];
    endfunction

    function automatic logic signed [15:0] to_mv(input logic signed [31:0] x);
        logic signed [31:0] q;
        q = x / 32'sd1000;
        return q[15:0];
    endfunction

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // ---------------------------------------------------------------------
    // FSM: next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (gate_valid) state_nxt = S_N2;
            S_N2:   state_nxt = S_N4;
            S_N4:   state_nxt = S_M2;
            S_M2:   state_nxt = S_M3;
            S_M3:   state_nxt = S_MH;
            S_MH:   state_nxt = S_IK;
            S_IK:   state_nxt = S_INA;
            S_INA:  state_nxt = S_IL;
            S_IL:   state_nxt = S_UPD;
            S_UPD:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs -- busy flag and shared multiplier operand select
    // ---------------------------------------------------------------------
    assign v48     = {{16{v_acc[31]}}, v_acc};
    assign istim_w = {{32{istim_r[15]}}, istim_r};

    // 10*i_stim converts 0.01 uA/cm^2 to 0.001 uA/cm^2
    assign i_sum = (istim_w <<< 3) + (istim_w <<< 1) - ik_r - ina_r - il_r;

    always_comb begin
        busy  = (state != S_IDLE);
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_N2: begin mul_a = ext_u(n_r);  mul_b = ext_u(n_r);  end
            S_N4: begin mul_a = n2_r;        mul_b = n2_r;        end
            S_M2: begin mul_a = ext_u(m_r);  mul_b = ext_u(m_r);  end
            S_M3: begin mul_a = m2_r;        mul_b = ext_u(m_r);  end
            S_MH: begin mul_a = m3_r;        mul_b = ext_u(h_r);  end
            // Conductance constants (36, 120) are applied by shift-add so the
            // shared multiplier only sees the conductance x driving-force term.
            S_IK: begin
                mul_a = (n4_r <<< 5) + (n4_r <<< 2);
                mul_b = v48 + 48'sd77000;
            end
            S_INA: begin
                mul_a = (gna_r <<< 7) - (gna_r <<< 3);
                mul_b = v48 - 48'sd50000;
            end
            S_IL: begin
                mul_a = 48'sd3;
                mul_b = v48 + 48'sd54400;
            end
            S_UPD: begin mul_a = i_sum; mul_b = ext_u(dt_r); end
            default: ;
        endcase
    end

    assign prod  = mul_a * mul_b;
    assign v_new = v48 + div1000(prod);
    assign v_sat = sat_v(v_new);

    // V (truncated toward zero) is negative only when v_acc <= -1000 uV, and
    // non-negative whenever v_acc > -1000 uV, so the crossing test needs no
    // divider.
    assign spike_now = (v_acc <= -32'sd1000) && (v_sat > -32'sd1000);

    assign V = to_mv(v_acc);

    // ---------------------------------------------------------------------
    // Datapath: input capture and per-state intermediate results
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        case (state)
            S_IDLE: begin
                if (gate_valid) begin
                    n_r     <= n;
                    m_r     <= m;
                    h_r     <= h;
                    istim_r <= i_stim;
                    dt_r    <= dt;
                end
            end
            S_N2:  n2_r  <= div1000(prod);
            S_N4:  n4_r  <= div1000(prod);
            S_M2:  m2_r  <= div1000(prod);
            S_M3:  m3_r  <= div1000(prod);
            S_MH:  gna_r <= div1000(prod);
            S_IK:  ik_r  <= div1000(prod);
            S_INA: ina_r <= div1000(prod);
            S_IL:  il_r  <= div10(prod);
            default: ;
        endcase
    end

    // ---------------------------------------------------------------------
    // Writeback: membrane potential and status pulses
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v_acc   <= V_REST;
            v_valid <= 1'b0;
            spike   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            v_valid <= (state == S_UPD);
            spike   <= (state == S_UPD) && spike_now;
            overrun <= gate_valid && busy;
            if (state == S_UPD)
                v_acc <= v_sat;
        end
    end

`ifdef HH_SPIKE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            spike_count <= '0;
        else if ((state == S_UPD) && spike_now)
            spike_count <= spike_count + 16'd1;
    end
`else
    assign spike_count = '0;
`endif

endmodule

// File: tb/tb_hh_membrane_update.sv
`timescale 1ns/1ps
module tb_hh_membrane_update;

    localparam int V_REST = -65000;
    localparam int V_MIN  = -120000;
    localparam int V_MAX  = 80000;

    logic               clk = 1'b0;
    logic               reset;
    logic               gate_valid;
    logic [15:0]        n, m, h, dt;
    logic signed [15:0] i_stim;
    logic signed [15:0] V;
    logic               v_valid, spike, busy, overrun;
    logic [15:0]        spike_count;

    hh_membrane_update #(
        .V_REST (V_REST),
        .V_MIN  (V_MIN),
        .V_MAX  (V_MAX)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .gate_valid  (gate_valid),
        .n           (n),
        .m           (m),
        .h           (h),
        .i_stim      (i_stim),
        .dt          (dt),
        .V           (V),
        .v_valid     (v_valid),
        .spike       (spike),
        .spike_count (spike_count),
        .busy        (busy),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic signed [15:0] v;
        logic               spk;
        logic [15:0]        cnt;
        int                 edge_no;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Reference model state
    longint mv;
    int     mcnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One forward-Euler step computed directly from the membrane equations.
    function automatic exp_t model_update(input longint nn, input longint mm,
                                          input longint hh, input longint is,
                                          input longint dd);
        longint n2, n4, m2, m3, g, ik, ina, il, isum, vn;
        exp_t   e;
        n2   = nn * nn / 1000;
        n4   = n2 * n2 / 1000;
        m2   = mm * mm / 1000;
        m3   = m2 * mm / 1000;
        g    = m3 * hh / 1000;
        ik   = 36 * n4 * (mv + 77000) / 1000;
        ina  = 120 * g * (mv - 50000) / 1000;
        il   = 3 * (mv + 54400) / 10;
        isum = 10 * is - ik - ina - il;
        vn   = mv + isum * dd / 1000;
        if (vn < V_MIN) vn = V_MIN;
        if (vn > V_MAX) vn = V_MAX;
        e.spk = ((mv / 1000) < 0) && ((vn / 1000) >= 0);
        if (e.spk) mcnt = (mcnt + 1) % 65536;
        mv      = vn;
        e.v     = 16'(mv / 1000);
`ifdef HH_SPIKE_CNT_EN
        e.cnt   = 16'(mcnt);
`else
        e.cnt   = 16'd0;
`endif
        e.edge_no = 0;
        return e;
    endfunction

    // Monitor: every v_valid pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (v_valid) begin
            if (sb.size() == 0) begin
                check("stray_v_valid", v_valid, 0);
            end else begin
                mon_e = sb.pop_front();
                check("V", V, mon_e.v);
                check("spike", spike, mon_e.spk);
                check("spike_count", spike_count, mon_e.cnt);
                check("latency", cyc, mon_e.edge_no + 9);
            end
        end
    end

    // Wait for idle, then present one set of gate values for a single edge.
    task automatic issue(input int nn, input int mm, input int hh,
                         input int is, input int dd, input bit expect_out);
        int   t;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (busy !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) begin
            check("busy_timeout", busy, 0);
            return;
        end
        gate_valid = 1'b1;
        n      = 16'(nn);
        m      = 16'(mm);
        h      = 16'(hh);
        i_stim = 16'(is);
        dt     = 16'(dd);
        if (expect_out) begin
            e = model_update(nn, mm, hh, is, dd);
            e.edge_no = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        gate_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((sb.size() != 0 || busy !== 1'b0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        mv   = V_REST;
        mcnt = 0;
        sb.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int spk_cnt_exp;
        reset      = 1'b1;
        gate_valid = 1'b0;
        n = '0; m = '0; h = '0; dt = '0; i_stim = '0;
        mv   = V_REST;
        mcnt = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Reset state
        check("rst_V", V, -65);
        check("rst_v_valid", v_valid, 0);
        check("rst_spike", spike, 0);
        check("rst_spike_count", spike_count, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);

        // Leak only
        issue(0, 0, 0, 0, 1000, 1);
        check("busy_after_accept", busy, 1);
        drain();
        check("leak_V", V, -61);

        // Potassium current
        do_reset();
        issue(1000, 0, 0, 0, 10, 1);
        drain();
        check("k_V", V, -69);

        // Spike, repeated update, then saturation
        do_reset();
        issue(0, 0, 0, 10000, 1000, 1);
        drain();
        check("spike_V", V, 38);
`ifdef HH_SPIKE_CNT_EN
        spk_cnt_exp = 1;
`else
        spk_cnt_exp = 0;
`endif
        check("spike_cnt_after", spike_count, spk_cnt_exp);
        issue(0, 0, 0, 10000, 1000, 1);
        drain();
        check("no_second_spike_cnt", spike_count, spk_cnt_exp);
        repeat (3) issue(0, 0, 0, 10000, 1000, 1);
        drain();
        check("sat_V", V, 80);

        // Reset in the middle of a sequence: no update follows
        issue(0, 0, 0, 10000, 1000, 0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_V", V, -65);
        check("midrst_busy", busy, 0);
        check("midrst_spike_count", spike_count, 0);
        @(negedge clk);
        reset = 1'b0;
        mv   = V_REST;
        mcnt = 0;
        repeat (20) @(negedge clk);
        check("midrst_V_after", V, -65);

        // Overrun: second gate_valid three edges after the accepted one
        do_reset();
        issue(0, 0, 0, 0, 1000, 1);
        repeat (2) @(negedge clk);
        gate_valid = 1'b1;
        n = 16'd1000; m = 16'd800; h = 16'd600; i_stim = -16'sd5000; dt = 16'd500;
        @(negedge clk);
        gate_valid = 1'b0;
        check("overrun_pulse", overrun, 1);
        @(negedge clk);
        check("overrun_clear", overrun, 0);
        drain();
        check("overrun_V", V, -61);

        // dt = 0 still produces an update pulse with unchanged potential
        issue(500, 500, 500, 3000, 0, 1);
        drain();
        check("dt0_V", V, -61);

        // Randomized back-to-back updates
        for (int i = 0; i < 60; i++) begin
            if (i % 12 == 0) begin
                drain();
                do_reset();
            end
            issue(int'($urandom_range(0, 1000)), int'($urandom_range(0, 1000)),
                  int'($urandom_range(0, 1000)),
                  int'($urandom_range(0, 40000)) - 20000,
                  int'($urandom_range(0, 2000)), 1);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hh_membrane_update.md
# hh_membrane_update

Hodgkin-Huxley membrane integrator: the consumer of the gating variables and the producer of membrane potential. Each time the gate blocks present updated n, m, h, it computes the K, Na and leak currents plus stimulus with one shared multiplier over a fixed 9-state sequence. It then performs one forward-Euler step on the membrane potential and drives V back to the gate blocks. Upward 0 mV crossings are flagged as spikes.

## Interface
Parameters:
- V_REST, -65000, reset membrane potential in µV
- V_MIN, -120000, lower saturation bound in µV
- V_MAX, 80000, upper saturation bound in µV

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- gate_valid  in  1  n/m/h/i_stim/dt valid; sampled only while busy=0
- n, m, h  in  16 each  gating variables ×1000, unsigned, 0..1000
- i_stim  in  16 signed  stimulus current, 0.01 µA/cm² units
- dt  in  16  time step in µs, unsigned
- V  out  16 signed  membrane potential in mV, to gate blocks
- v_valid  out  1  one-cycle pulse: V updated
- spike  out  1  one-cycle pulse coincident with v_valid on upward 0 mV crossing
- spike_count  out  16  spikes since reset
- busy  out  1  computation in progress
- overrun  out  1  one-cycle pulse: gate_valid arrived while busy

## Operation
- Internal state v_acc: signed 32-bit, µV. V = v_acc / 1000, signed divide truncating toward zero.
- FSM: IDLE → N2 → N4 → M2 → M3 → MH → IK → INA → IL → UPD → IDLE. Exactly one multiply per state.
- IDLE: on gate_valid, capture n, m, h, i_stim, dt into registers, then enter N2.
- N2: n2 = n·n/1000. N4: n4 = n2·n2/1000.
- M2: m2 = m·m/1000. M3: m3 = m2·m/1000. MH: g_na = m3·h/1000.
- IK: i_k = 36·n4·(v_acc+77000)/1000.
- INA: i_na = 120·g_na·(v_acc−50000)/1000.
- IL: i_l = 3·(v_acc+54400)/10.
- UPD: i_sum = 10·i_stim − i_k − i_na − i_l (units 0.001 µA/cm²). Then v_new = v_acc + i_sum·dt/1000, with C = 1 µF/cm².
- Arithmetic: all intermediates signed 48-bit. Divides are signed and truncate toward zero. v_new saturates to [V_MIN, V_MAX] before writeback.
- Spike: asserted when the old V < 0 and the new V ≥ 0. spike_count increments by 1 per spike and wraps at 65535→0.
- gate_valid while busy=1: ignored, with an overrun pulse on the next cycle. Captured registers and the computation are unaffected.
- dt = 0: full sequence runs; v_acc unchanged; v_valid still pulses.
- Reset mid-sequence: abort immediately. No v_valid, no spike.

## Timing
- Reset values: v_acc = V_REST (V = −65), v_valid = 0, spike = 0, spike_count = 0, busy = 0, overrun = 0, FSM = IDLE.
- gate_valid sampled high at edge k with busy = 0 → busy high after edges k..k+8.
- At edge k+9: V, v_valid, spike and spike_count update, and FSM returns to IDLE.
- v_valid/spike high for exactly the cycle following edge k+9.
- Earliest next accept is edge k+10. Maximum throughput is one update per 10 cycles.
- V is stable between v_valid pulses, so gate blocks may sample it at any time.

## Configuration
- HH_SPIKE_CNT_EN defined: the spike_count register is implemented as described.
- Not defined: spike_count tied to 0 and no counter logic. spike pulse behaviour is unchanged.

## Test plan
- Reset: assert reset mid-sequence (edge k+4) → V = −65, spike_count = 0, busy = 0, and no v_valid follows.
- Leak only: n = m = h = 0, i_stim = 0, dt = 1000 → v_acc = −61820, V = −61, v_valid 9 edges after accept, spike = 0.
- K current: n = 1000, m = h = 0, i_stim = 0, dt = 10 → i_k = 432000, v_acc = −69288, V = −69.
- Spike: n = m = h = 0, i_stim = 10000, dt = 1000 → v_acc = 38180, V = 38, spike pulse with v_valid, spike_count = 1. A second identical update gives no new spike.
- Saturation: repeat the spike stimulus 3 more times → V = 80 (clamped) and remains 80.
- Overrun: gate_valid pulsed at k and again at k+3 → overrun pulse, only one v_valid, and the result equals the single-update value.
